// File: rtl/flag_unit.sv
// Flag register {V,S,C,Z} for the MEH accumulator, with pending Z/S and C/V refresh,
// a direct write port and a small save stack for interrupt entry and exit.
module flag_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           a_out,
    input  logic                       a_load,
    input  logic                       alu_op,
    input  logic                       a_op,
    input  logic                       alu_c_flag,
    input  logic                       alu_v_flag,
    input  logic                       a_c_flag,
    input  logic                       flags_we,
    input  logic [3:0]                 flags_wdata,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       err_clr,
    output logic [3:0]                 out,
    output logic [$clog2(DEPTH+1)-1:0] depth_cnt,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       stack_err
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [3:0]    flags_q, flags_d;
    logic          pend_zs_q, pend_zs_d;
    logic          pend_alu_q, pend_alu_d;
    logic          pend_a_q, pend_a_d;
    logic [3:0]    stack_q [DEPTH];
    logic [3:0]    stack_d [DEPTH];
    logic [CW-1:0] depth_q, depth_d;
    logic          err_q, err_d;

    logic          full_s, empty_s;
    logic          push_ok_s, pop_ok_s, err_ev_s;
    logic [3:0]    top_s;
    logic [3:0]    upd_s;

    // Stack validity decode and top-of-stack selection.
    always_comb begin
        full_s    = (depth_q == CW'(DEPTH));
        empty_s   = (depth_q == {CW{1'b0}});
        push_ok_s = push & ~pop & ~full_s;
        pop_ok_s  = pop & ~push & ~empty_s;
        err_ev_s  = (push & pop) | (push & ~pop & full_s) | (pop & ~push & empty_s);
        top_s     = flags_q;
        for (int i = 0; i < DEPTH; i++) begin
            top_s = (depth_q == CW'(i + 1)) ? stack_q[i] : top_s;
        end
    end

    // Pending flag refresh; each pending bit consumes the inputs present at this edge.
    always_comb begin
        upd_s = flags_q;
        if (pend_zs_q) begin
            upd_s[0] = (a_out == {WIDTH{1'b0}});
            upd_s[2] = a_out[WIDTH-1];
        end else begin
            upd_s[0] = flags_q[0];
            upd_s[2] = flags_q[2];
        end
        if (pend_alu_q) begin
            upd_s[1] = alu_c_flag;
            upd_s[3] = alu_v_flag;
        end else if (pend_a_q) begin
            upd_s[1] = a_c_flag;
            upd_s[3] = flags_q[3];
        end else begin
            upd_s[1] = flags_q[1];
            upd_s[3] = flags_q[3];
        end
    end

    // Next-state: pop beats direct write beats pending refresh; strobes always captured.
    always_comb begin
        pend_zs_d  = a_load;
        pend_alu_d = alu_op;
        pend_a_d   = a_op & ~alu_op;

        if (pop_ok_s) begin
            flags_d = top_s;
        end else if (flags_we) begin
            flags_d = flags_wdata;
        end else begin
            flags_d = upd_s;
        end

        for (int i = 0; i < DEPTH; i++) begin
            stack_d[i] = (push_ok_s && (depth_q == CW'(i))) ? flags_q : stack_q[i];
        end

        if (push_ok_s) begin
            depth_d = depth_q + CW'(1);
        end else if (pop_ok_s) begin
            depth_d = depth_q - CW'(1);
        end else begin
            depth_d = depth_q;
        end

        if (err_ev_s) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State registers; stack contents are not reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q    <= 4'b0001;
            pend_zs_q  <= 1'b0;
            pend_alu_q <= 1'b0;
            pend_a_q   <= 1'b0;
            depth_q    <= {CW{1'b0}};
            err_q      <= 1'b0;
        end else begin
            flags_q    <= flags_d;
            pend_zs_q  <= pend_zs_d;
            pend_alu_q <= pend_alu_d;
            pend_a_q   <= pend_a_d;
            depth_q    <= depth_d;
            err_q      <= err_d;
        end
    end

    // Stack storage.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            stack_q[i] <= stack_d[i];
        end
    end

    assign out         = flags_q;
    assign depth_cnt   = depth_q;
    assign stack_full  = full_s;
    assign stack_empty = empty_s;
    assign stack_err   = err_q;

endmodule

// File: tb/tb_flag_unit.sv
// Scoreboard bench for flag_unit: stimulus queues expected state per cycle,
// a negedge monitor pops and compares against the WIDTH=16 and WIDTH=8 instances.
module tb_flag_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a_out16;
    logic [7:0]  a_out8;
    logic        a_load, alu_op, a_op, alu_c_flag, alu_v_flag, a_c_flag;
    logic        flags_we, push, pop, err_clr;
    logic [3:0]  flags_wdata;
    logic [3:0]  out16, out8;
    logic [2:0]  depth16, depth8;
    logic        full16, empty16, err16, full8, empty8, err8;

    int cycle_cnt = 0;
    int n_checks  = 0;
    int n_fail    = 0;

    typedef struct {
        int         cyc;
        bit         sel8;
        logic [3:0] o;
        logic [2:0] d;
        logic       e;
        string      name;
    } exp_t;
    exp_t sb_q[$];

    flag_unit #(.WIDTH(16), .DEPTH(4)) u16 (
        .clk(clk), .rst_n(rst_n), .a_out(a_out16), .a_load(a_load), .alu_op(alu_op),
        .a_op(a_op), .alu_c_flag(alu_c_flag), .alu_v_flag(alu_v_flag), .a_c_flag(a_c_flag),
        .flags_we(flags_we), .flags_wdata(flags_wdata), .push(push), .pop(pop),
        .err_clr(err_clr), .out(out16), .depth_cnt(depth16), .stack_full(full16),
        .stack_empty(empty16), .stack_err(err16)
    );

    flag_unit #(.WIDTH(8), .DEPTH(4)) u8 (
        .clk(clk), .rst_n(rst_n), .a_out(a_out8), .a_load(a_load), .alu_op(alu_op),
        .a_op(a_op), .alu_c_flag(alu_c_flag), .alu_v_flag(alu_v_flag), .a_c_flag(a_c_flag),
        .flags_we(flags_we), .flags_wdata(flags_wdata), .push(push), .pop(pop),
        .err_clr(err_clr), .out(out8), .depth_cnt(depth8), .stack_full(full8),
        .stack_empty(empty8), .stack_err(err8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cycle_cnt);
        end
    endtask

    // Monitor: compare every expectation due at this cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cycle_cnt) begin
            exp_t x;
            x = sb_q.pop_front();
            if (x.cyc < cycle_cnt) begin
                chk({x.name, "_stale"}, cycle_cnt, x.cyc);
            end else if (x.sel8) begin
                chk({x.name, "_out8"}, int'(out8), int'(x.o));
            end else begin
                chk({x.name, "_out"},   int'(out16),   int'(x.o));
                chk({x.name, "_depth"}, int'(depth16), int'(x.d));
                chk({x.name, "_err"},   int'(err16),   int'(x.e));
                chk({x.name, "_full"},  int'(full16),  int'(x.d == 3'd4));
                chk({x.name, "_empty"}, int'(empty16), int'(x.d == 3'd0));
            end
        end
    end

    // Expect state after the next rising edge (now=0) or in the current cycle (now=1).
    task automatic expect_st(input string name, input logic [3:0] o, input logic [2:0] d,
                             input logic e, input bit sel8 = 1'b0, input bit now = 1'b0);
        exp_t x;
        x.cyc  = now ? cycle_cnt : cycle_cnt + 1;
        x.sel8 = sel8;
        x.o    = o;
        x.d    = d;
        x.e    = e;
        x.name = name;
        sb_q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_load = 1'b0; alu_op = 1'b0; a_op = 1'b0;
        flags_we = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        a_out16 = 16'h0000; a_out8 = 8'h00; flags_wdata = 4'b0000;
        alu_c_flag = 1'b0; alu_v_flag = 1'b0; a_c_flag = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        expect_st("reset", 4'b0001, 3'd0, 1'b0, 1'b0, 1'b1);
        expect_st("reset8", 4'b0001, 3'd0, 1'b0, 1'b1, 1'b1);

        // Z/S latency and sign on both widths
        a_load = 1'b1; a_out16 = 16'h0001; a_out8 = 8'h01;
        expect_st("zs_latency", 4'b0001, 3'd0, 1'b0);
        tick();
        idle(); a_out16 = 16'h8000; a_out8 = 8'h80;
        expect_st("zs_sign", 4'b0100, 3'd0, 1'b0);
        expect_st("w8_sign", 4'b0100, 3'd0, 1'b0, 1'b1);
        tick();
        a_load = 1'b1;
        tick();
        idle(); a_out16 = 16'h0000; a_out8 = 8'h00;
        expect_st("zs_zero", 4'b0001, 3'd0, 1'b0);
        tick();

        // Carry merge: ALU wins, then A shift carry alone
        alu_op = 1'b1; a_op = 1'b1;
        tick();
        idle(); alu_c_flag = 1'b1; alu_v_flag = 1'b1; a_c_flag = 1'b0;
        expect_st("alu_cv", 4'b1011, 3'd0, 1'b0);
        tick();
        a_op = 1'b1;
        tick();
        idle();
        expect_st("a_carry", 4'b1001, 3'd0, 1'b0);
        tick();
        alu_c_flag = 1'b0; alu_v_flag = 1'b0;

        // Direct write, push, overwrite, pop
        flags_we = 1'b1; flags_wdata = 4'b1010;
        expect_st("we", 4'b1010, 3'd0, 1'b0);
        tick();
        idle(); push = 1'b1;
        expect_st("push1", 4'b1010, 3'd1, 1'b0);
        tick();
        idle(); flags_we = 1'b1; flags_wdata = 4'b0101;
        expect_st("we2", 4'b0101, 3'd1, 1'b0);
        tick();
        idle(); pop = 1'b1;
        expect_st("pop1", 4'b1010, 3'd0, 1'b0);
        tick();

        // Fill with push+write: old value saved, new value written
        for (int k = 1; k <= 4; k++) begin
            idle(); push = 1'b1; flags_we = 1'b1; flags_wdata = 4'(k);
            expect_st("fill", 4'(k), 3'(k), 1'b0);
            tick();
        end
        idle(); push = 1'b1;
        expect_st("push_full", 4'b0100, 3'd4, 1'b1);
        tick();
        idle(); err_clr = 1'b1;
        expect_st("err_clr", 4'b0100, 3'd4, 1'b0);
        tick();
        idle(); pop = 1'b1;
        expect_st("pop_d3", 4'b0011, 3'd3, 1'b0);
        tick();
        expect_st("pop_d2", 4'b0010, 3'd2, 1'b0);
        tick();

        // push+pop conflict: ignored, direct write still applies
        idle(); push = 1'b1; pop = 1'b1; flags_we = 1'b1; flags_wdata = 4'b0111;
        expect_st("push_pop", 4'b0111, 3'd2, 1'b1);
        tick();
        idle(); err_clr = 1'b1; push = 1'b1; pop = 1'b1;
        expect_st("clr_vs_err", 4'b0111, 3'd2, 1'b1);
        tick();
        idle(); err_clr = 1'b1;
        expect_st("err_clr2", 4'b0111, 3'd2, 1'b0);
        tick();

        // Pending ALU update discarded by a pop at the consuming edge
        idle(); alu_op = 1'b1;
        tick();
        idle(); pop = 1'b1; alu_c_flag = 1'b1; alu_v_flag = 1'b1;
        expect_st("pop_vs_alu", 4'b0001, 3'd1, 1'b0);
        tick();
        idle();
        expect_st("pop_vs_alu_hold", 4'b0001, 3'd1, 1'b0);
        tick();
        pop = 1'b1;
        expect_st("pop_last", 4'b1010, 3'd0, 1'b0);
        tick();
        expect_st("pop_empty", 4'b1010, 3'd0, 1'b1);
        tick();

        // Mid-cycle reset with a pending ALU update outstanding
        idle(); alu_op = 1'b1;
        tick();
        idle(); rst_n = 1'b0;
        expect_st("rst_mid", 4'b0001, 3'd0, 1'b0, 1'b0, 1'b1);
        tick();
        rst_n = 1'b1;
        expect_st("rst_pend_clr", 4'b0001, 3'd0, 1'b0);
        tick();
        tick();

        chk("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flag_unit.md
# flag_unit

Parametrised flag register for the MEH datapath. It tracks Zero, Carry, Sign and Overflow for a WIDTH-bit accumulator and merges carry/overflow from the ALU and the accumulator's own shift/rotate carry. It adds a direct flag write port and a DEPTH-entry flag save stack for interrupt entry and exit. It sits between the A register / ALU and the control unit, whose branch logic consumes `out`.

## Interface
Parameters:
- WIDTH, 16, accumulator width; sign is bit WIDTH-1
- DEPTH, 4, flag stack entries (≥1)

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_out  in  WIDTH  current accumulator value
- a_load  in  1  accumulator was written this cycle; Z/S refresh pending
- alu_op  in  1  ALU operation strobe; C/V refresh from ALU pending
- a_op  in  1  accumulator shift/rotate strobe; C refresh from A pending
- alu_c_flag  in  1  ALU carry out
- alu_v_flag  in  1  ALU signed overflow
- a_c_flag  in  1  accumulator shift carry out
- flags_we  in  1  direct flag write
- flags_wdata  in  4  value for flags_we, {V,S,C,Z}
- push  in  1  save `out` onto the stack
- pop  in  1  restore `out` from the stack
- err_clr  in  1  clear stack_err
- out  out  4  flags {V,S,C,Z}; Z=bit0, C=bit1, S=bit2, V=bit3
- depth_cnt  out  $clog2(DEPTH+1)  entries on stack
- stack_full  out  1  depth_cnt == DEPTH
- stack_empty  out  1  depth_cnt == 0
- stack_err  out  1  sticky stack misuse indicator

## Operation
- State: flags register (4b), pend_zs, pend_alu, pend_a, stack array DEPTH×4, depth_cnt, stack_err.
- Reset (rst_n low, immediate): out=4'b0001 (Z=1), all pending bits 0, depth_cnt=0, stack_err=0. Stack contents are don't-care.
- Strobe capture, every edge: pend_zs<=a_load; pend_alu<=alu_op; pend_a<=a_op & ~alu_op. alu_op wins over a_op in the same cycle.
- Pending consumption, same edge as capture, using the value the pending bit held before the edge:
  - pend_zs: Z<=(a_out==0), S<=a_out[WIDTH-1].
  - pend_alu: C<=alu_c_flag, V<=alu_v_flag.
  - pend_a: C<=a_c_flag; V unchanged.
  - Bits with no pending update hold.
- Override priority per edge, highest first:
  - valid pop: out<=stack top.
  - flags_we: out<=flags_wdata.
  - pending updates.
  - A pop or flags_we replaces all four bits and discards any pending consumption that edge. New strobes are still captured.
- Stack:
  - valid push: write `out` (pre-edge value) to entry depth_cnt; depth_cnt+1.
  - valid pop: depth_cnt-1. out takes entry depth_cnt-1.
- Errors, each setting stack_err=1 with no stack or flag change from the stack op:
  - push while full;
  - pop while empty;
  - push and pop in the same cycle. Both are ignored; flags_we and pending updates still apply.
- stack_err stays 1 until an err_clr edge. If err_clr and a new error occur on the same edge, stack_err=1.
- push with flags_we the same cycle: the old flags are pushed and the new value is written.

## Timing
- Z/S/C/V change exactly one edge after the edge that sampled the strobe. With a strobe at edge N, `out` reflects a_out/carries sampled at edge N+1.
- flags_we and pop take effect at the sampling edge (0-cycle latency after the edge).
- Back-to-back strobes every cycle: each edge consumes the prior strobe and captures the next; no updates are lost.
- stack_full, stack_empty and `out` are registered-state derived; no combinational input-to-output path.
- Reset mid-operation clears pending updates; a strobe present at rst_n release is sampled on the first edge after release.

## Test plan
- Reset: assert rst_n=0 mid-cycle → out=0001, depth_cnt=0, stack_empty=1, stack_err=0 before the next edge.
- Z/S latency: a_load at edge N with a_out=16'h8000 at N+1 → out[2:0]=100 after N+1. Then a_load with a_out=0 → Z=1, S=0.
- Carry merge: alu_op and a_op together at N, alu_c_flag=1, alu_v_flag=1, a_c_flag=0 at N+1 → C=1, V=1. a_op alone, a_c_flag=0 → C=0, V stays 1.
- Stack: set flags 1010 via flags_we; push; flags_we 0101; pop → out=1010, depth_cnt=0. Fill DEPTH=4 entries, push again → stack_full=1, stack_err=1, depth_cnt=4. err_clr → stack_err=0.
- Conflicts: pop on empty → stack_err=1, out unchanged. push+pop together with depth 2 → depth stays 2, stack_err=1. Pending alu_op plus pop at the same edge → out equals the popped value.
- WIDTH=8 instance: a_load with a_out=8'h80 → S=1, Z=0.
